// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit FND scan controller.
package fnd_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] COM_OFF  = 4'hF;

  localparam logic [3:0] DIGIT_DASH = 4'hF;

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_pos_e;
  typedef enum logic {MODE_SM = 1'b0, MODE_HM = 1'b1} mode_e;

  typedef struct packed {
    mode_e      mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
  } snap_t;

  // {tens, ones}; an out-of-range value turns both digits into dashes.
  function automatic logic [7:0] bcd_pair(input logic [6:0] v, input logic [6:0] lim);
    if (v > lim) begin
      return {DIGIT_DASH, DIGIT_DASH};
    end
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational digit-to-segment decoder for a common-anode display (active-low).
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      DIGIT_DASH: seg = SEG_DASH;
      default:    seg = SEG_OFF;
    endcase
    if (dp) begin
      seg[7] = 1'b0;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 4-digit FND driver: per-frame time snapshot, BCD split and registered outputs.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sel_hm,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int unsigned TICK_DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt_q;
  logic             tick;
  digit_pos_e       digit_q, digit_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       hi_pair, lo_pair;
  logic [3:0]       digit_code;
  logic             dp_on;
  logic [7:0]       seg;
  logic [3:0]       com_q;
  logic [7:0]       data_q;

  always_comb begin
    tick    = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    digit_d = tick ? digit_pos_e'(digit_q + 2'd1) : digit_q;
    snap_d  = snap_q;
    // Frame start: the whole frame is drawn from this one coherent sample.
    if (tick && (digit_q == D3)) begin
      snap_d = '{mode: mode_e'(i_sel_hm), msec: msec, sec: sec, min: min, hour: hour};
    end
  end

  always_comb begin
    if (snap_d.mode == MODE_HM) begin
      hi_pair = bcd_pair({2'b00, snap_d.hour}, 7'd23);
      lo_pair = bcd_pair({1'b0, snap_d.min}, 7'd59);
    end else begin
      hi_pair = bcd_pair({1'b0, snap_d.sec}, 7'd59);
      lo_pair = bcd_pair(snap_d.msec, 7'd99);
    end
    unique case (digit_d)
      D0:      digit_code = lo_pair[3:0];
      D1:      digit_code = lo_pair[7:4];
      D2:      digit_code = hi_pair[3:0];
      D3:      digit_code = hi_pair[7:4];
      default: digit_code = DIGIT_DASH;
    endcase
    // Half-second blink; out-of-range msec (>=100) is naturally excluded.
    dp_on = (digit_d == D2) && (snap_d.msec < 7'd50);
  end

  fnd_seg_decoder u_seg_decoder (
    .digit (digit_code),
    .dp    (dp_on),
    .seg   (seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      digit_q    <= D3;
      snap_q     <= '0;
      com_q      <= COM_OFF;
      data_q     <= SEG_OFF;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      digit_q    <= digit_d;
      snap_q     <= snap_d;
      if (tick) begin
        com_q  <= ~(4'b0001 << digit_d);
        data_q <= seg;
      end
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: directed scenarios plus random inputs vs. a time-based model.
module tb_fnd_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       sel_hm;
  logic [6:0] in_msec;
  logic [5:0] in_sec;
  logic [5:0] in_min;
  logic [4:0] in_hour;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int total;
  int bad;

  // Model state: edges since reset released, frame snapshot, expected outputs.
  int         edges;
  int         m_mode, m_msec, m_sec, m_min, m_hour;
  logic [3:0] exp_com;
  logic [7:0] exp_data;
  logic [7:0] seg_tab [10];

  fnd_scan_ctrl #(
    .CLK_FREQ (100),
    .SCAN_HZ  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_sel_hm (sel_hm),
    .msec     (in_msec),
    .sec      (in_sec),
    .min      (in_min),
    .hour     (in_hour),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_data(input int d);
    int v, vmax, dig;
    logic [7:0] code;
    if (d >= 2) begin
      v    = (m_mode != 0) ? m_hour : m_sec;
      vmax = (m_mode != 0) ? 23 : 59;
    end else begin
      v    = (m_mode != 0) ? m_min : m_msec;
      vmax = (m_mode != 0) ? 59 : 99;
    end
    if (v > vmax) begin
      code = 8'hBF;
    end else begin
      dig  = (d % 2 == 1) ? v / 10 : v % 10;
      code = seg_tab[dig];
    end
    if (d == 2 && m_msec < 50) code[7] = 1'b0;
    return code;
  endfunction

  task automatic model_edge();
    int k, d;
    if (rst) begin
      edges    = 0;
      m_mode   = 0; m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0;
      exp_com  = 4'hF;
      exp_data = 8'hFF;
    end else begin
      edges++;
      if (edges % 10 == 0) begin
        k = edges / 10;
        d = (k - 1) % 4;
        if (d == 0) begin
          m_mode = int'(sel_hm); m_msec = int'(in_msec); m_sec = int'(in_sec);
          m_min  = int'(in_min); m_hour = int'(in_hour);
        end
        exp_com  = ~(4'b0001 << d);
        exp_data = model_data(d);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("com", {4'h0, fnd_com}, {4'h0, exp_com});
    chk("data", fnd_data, exp_data);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input logic m, input int ms, input int s, input int mi, input int h);
    sel_hm  = m;
    in_msec = 7'(ms);
    in_sec  = 6'(s);
    in_min  = 6'(mi);
    in_hour = 5'(h);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edges = 0;
    m_mode = 0; m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0;
    exp_com = 4'hF; exp_data = 8'hFF;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst = 1'b1;
    set_in(1'b0, 0, 0, 0, 0);
    #2;

    // Scenario 1: reset state and first digit.
    run(2);
    chk("rst_com", {4'h0, fnd_com}, 8'h0F);
    chk("rst_data", fnd_data, 8'hFF);
    rst = 1'b0;
    run(9);
    chk("s1_off_com", {4'h0, fnd_com}, 8'h0F);
    run(1);
    chk("s1_d0_com", {4'h0, fnd_com}, 8'h0E);
    chk("s1_d0_data", fnd_data, 8'hC0);
    set_in(1'b0, 56, 34, 0, 0);
    run(10);
    chk("s1_d1_com", {4'h0, fnd_com}, 8'h0D);
    run(10);
    chk("s1_d2_com", {4'h0, fnd_com}, 8'h0B);
    run(10);
    chk("s1_d3_com", {4'h0, fnd_com}, 8'h07);

    // Scenario 2: mode 0, 34.56.
    run(10); chk("s2_d0", fnd_data, 8'h82);
    run(10); chk("s2_d1", fnd_data, 8'h92);
    run(10); chk("s2_d2", fnd_data, 8'h99);
    run(10); chk("s2_d3", fnd_data, 8'hB0);

    // Scenario 3: msec=12 lights dp on digit 2.
    set_in(1'b0, 12, 34, 0, 0);
    run(10); chk("s3_d0", fnd_data, 8'hA4);
    run(10); chk("s3_d1", fnd_data, 8'hF9);
    run(10); chk("s3_d2", fnd_data, 8'h19);
    run(10); chk("s3_d3", fnd_data, 8'hB0);

    // Scenario 4: mode 1, 23:07.
    set_in(1'b1, 56, 34, 7, 23);
    run(10); chk("s4_d0", fnd_data, 8'hF8);
    run(10); chk("s4_d1", fnd_data, 8'hC0);
    run(10); chk("s4_d2", fnd_data, 8'hB0);
    run(10); chk("s4_d3", fnd_data, 8'hA4);

    // Scenario 5: change mid-frame is not visible until the next frame.
    set_in(1'b0, 56, 34, 7, 23);
    run(20);
    chk("s5_d1_com", {4'h0, fnd_com}, 8'h0D);
    set_in(1'b0, 56, 35, 7, 23);
    run(10); chk("s5_d2_old", fnd_data, 8'h99);
    run(10); chk("s5_d3_old", fnd_data, 8'hB0);
    run(30); chk("s5_d2_new", fnd_data, 8'h92);

    // Scenario 6: out-of-range sec, then reset during digit 2.
    set_in(1'b0, 56, 60, 7, 23);
    run(40); chk("s6_d2_dash", fnd_data, 8'hBF);
    run(10); chk("s6_d3_dash", fnd_data, 8'hBF);
    run(30);
    chk("s6_pre_com", {4'h0, fnd_com}, 8'h0B);
    rst = 1'b1;
    run(1);
    chk("s6_rst_com", {4'h0, fnd_com}, 8'h0F);
    chk("s6_rst_data", fnd_data, 8'hFF);
    rst = 1'b0;
    run(9);
    chk("s6_off_com", {4'h0, fnd_com}, 8'h0F);
    run(1);
    chk("s6_restart_com", {4'h0, fnd_com}, 8'h0E);
    chk("s6_restart_data", fnd_data, 8'h82);

    // Random phase: inputs change at random times, occasional out-of-range and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_in(1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 99),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23));
      end
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Downstream display stage for the stopwatch time outputs (msec/sec/min/hour).
- Time-multiplexes a 4-digit common-anode 7-segment display (FND).
- Latches a coherent snapshot of the time once per scan frame and splits each field into BCD digits.
- Drives active-low digit-select and segment lines, with a half-second blinking decimal point.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. TICK_DIV = CLK_FREQ/SCAN_HZ, which must be at least 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_sel_hm  in  1  display mode: 0 = sec:msec, 1 = hour:min.
- msec  in  7  centiseconds, valid range 0..99.
- sec  in  6  seconds, valid range 0..59.
- min  in  6  minutes, valid range 0..59.
- hour  in  5  hours, valid range 0..23.
- fnd_com  out  4  digit enables, active low; bit0 = rightmost digit.
- fnd_data  out  8  segments, active low; bit7 = dp, bits 6:0 = g,f,e,d,c,b,a.

Behaviour:
- Reset (rst=1 at a clock edge) forces all state to its reset value on that edge:
  - tick_cnt=0, digit_idx=3, snapshot cleared to zero, snapshot mode=0.
  - fnd_com=4'b1111 (display off), fnd_data=8'hFF.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted for one cycle when tick_cnt==TICK_DIV-1.
- Digit index:
  - On tick, digit_idx increments modulo 4 (3 wraps to 0).
  - The first tick after reset selects digit 0.
- Snapshot:
  - On tick with digit_idx==3 (frame start), register {i_sel_hm, msec, sec, min, hour}.
  - Inputs are ignored at all other times, so no tearing within a frame.
- Outputs are registered and update on the same edge as digit_idx:
  - fnd_com = ~(1<<new digit_idx).
  - fnd_data = encoding of the new digit, taken from the snapshot as updated on that same edge.
  - Between ticks, the outputs hold their value.
- Digit mapping, mode 0: d3 = sec tens, d2 = sec ones, d1 = msec tens, d0 = msec ones.
- Digit mapping, mode 1: d3 = hour tens, d2 = hour ones, d1 = min tens, d0 = min ones.
- BCD split: tens = v/10, ones = v%10 (combinational from the snapshot).
- Segment codes (dp off), 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
- Out-of-range field (msec>99, sec>59, min>59, hour>23): both digits of that pair show a dash, 8'hBF (only segment g lit).
- Decimal point:
  - Lit (bit7=0) only on digit 2, and only when snapshot msec<50. This applies in both modes and gives a 1 Hz blink.
  - An out-of-range msec counts as ≥50, so dp is off.
  - A dash on digit 2 still shows dp if the rule holds.
- No leading-zero blanking; all four digits are always driven.
- Reset during a scan takes effect on the next edge with the values above. The scan restarts from a new frame and a new snapshot.
- When rst and tick coincide, reset wins.

Decomposition:
- Shared package fnd_pkg holds:
  - constants SEG_0..SEG_9, SEG_DASH=8'hBF, SEG_OFF=8'hFF, COM_OFF=4'hF;
  - a digit-position enum: D0..D3;
  - a mode enum: MODE_SM=0, MODE_HM=1.
- One sub-module, fnd_seg_decoder: a combinational 4-bit digit plus dp flag in, 8-bit segment code out. A digit code of 4'hF maps to a dash.
- Tick generator, digit counter, snapshot, BCD split and output registers all stay in fnd_scan_ctrl.

Test Plan:
All scenarios use CLK_FREQ=100, SCAN_HZ=10, so TICK_DIV=10.
1. Release reset → fnd_com=1111 and fnd_data=FF for 10 cycles. Then fnd_com=1110, and fnd_data shows the digit-0 code (C0 with zero inputs); fnd_com rotates 1110→1101→1011→0111 every 10 cycles.
2. Mode 0, sec=34, msec=56, one full frame →
   - digit 0: 1110/82
   - digit 1: 1101/92
   - digit 2: 1011/99 (dp off)
   - digit 3: 0111/B0
3. Mode 0, sec=34, msec=12 → digit 2 gives fnd_data=19 (dp lit), digit 1 gives F9, digit 0 gives A4.
4. Mode 1, hour=23, min=7 → digits 0..3 give F8, C0, B0, A4.
5. Snapshot coherence: change sec 34→35 while digit 1 is shown → rest of that frame still shows 4 on digit 2; the next frame shows 92 on digit 2.
6. sec=60 → digits 3 and 2 show BF. Then assert rst for 1 cycle during digit 2 → on the next edge fnd_com=1111 and fnd_data=FF, and the scan restarts at digit 0 after 10 cycles.
